mem_arbiter: RTL

- Shares one unified instruction/data memory port between the fetch stage (instruction reads) and the load/store unit (data reads/writes).
- Sits between both requesters and the memory.
- Serializes accesses with one outstanding transaction at a time and alternates fairly under contention.
- Routes each response back to its owner and raises an error response if memory stops answering.

---
 rtl/rv32i_pkg.sv | 20 ++
 rtl/arb_timeout_counter.sv | 37 +++
 rtl/mem_arbiter.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
// Shared types and constants for the unified instruction/data memory port.
package rv32i_pkg;

  localparam int XLEN = 32;
  localparam logic [3:0] FETCH_MASK = 4'b1111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic            we_re;
    logic [3:0]      mask;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/arb_timeout_counter.sv
// Saturating busy-cycle counter; tc_o flags the last cycle before a timeout.
module arb_timeout_counter #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] TcVal  = CntW'(TIMEOUT - 1);
  localparam logic [CntW-1:0] SatVal = CntW'(TIMEOUT);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != SatVal)) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == TcVal);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one memory port between fetch and load/store, one access in flight,
// round-robin under contention, with a timeout error response.
module mem_arbiter
  import rv32i_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 if_req,
  input  logic [DataWidth-1:0] if_addr,
  output logic                 if_gnt,
  output logic                 if_valid,
  output logic                 if_err,
  output logic [DataWidth-1:0] if_rdata,
  input  logic                 d_req,
  input  logic                 d_we_re,
  input  logic [3:0]           d_mask,
  input  logic [DataWidth-1:0] d_addr,
  input  logic [DataWidth-1:0] d_wdata,
  output logic                 d_gnt,
  output logic                 d_valid,
  output logic                 d_err,
  output logic [DataWidth-1:0] d_rdata,
  output logic                 mem_request,
  output logic                 mem_we_re,
  output logic [3:0]           mem_mask,
  output logic [DataWidth-1:0] mem_addr,
  output logic [DataWidth-1:0] mem_wdata,
  input  logic                 mem_valid,
  input  logic [DataWidth-1:0] mem_rdata
);

  arb_state_e state_q, state_d;
  logic last_d_q, last_d_d;
  mem_req_t req_q, req_d, req_sel;
  logic mem_request_q, mem_request_d;
  logic if_gnt_q, if_gnt_d, d_gnt_q, d_gnt_d;
  logic if_valid_q, if_valid_d, d_valid_q, d_valid_d;
  logic if_err_q, if_err_d, d_err_q, d_err_d;
  logic [DataWidth-1:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic pick_d, cnt_clr, cnt_en, cnt_tc;

  // On a tie the requester that was not served last wins.
  assign pick_d = d_req && (!if_req || !last_d_q);

  always_comb begin
    if (pick_d) begin
      req_sel.we_re = d_we_re;
      req_sel.mask  = d_mask;
      req_sel.addr  = d_addr;
      req_sel.wdata = d_wdata;
    end else begin
      req_sel.we_re = 1'b0;
      req_sel.mask  = FETCH_MASK;
      req_sel.addr  = if_addr;
      req_sel.wdata = '0;
    end
  end

  always_comb begin
    state_d       = state_q;
    last_d_d      = last_d_q;
    req_d         = req_q;
    mem_request_d = mem_request_q;
    if_gnt_d      = 1'b0;
    d_gnt_d       = 1'b0;
    if_valid_d    = 1'b0;
    d_valid_d     = 1'b0;
    if_err_d      = 1'b0;
    d_err_d       = 1'b0;
    if_rdata_d    = if_rdata_q;
    d_rdata_d     = d_rdata_q;
    cnt_clr       = 1'b0;
    cnt_en        = 1'b0;
    case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          state_d       = pick_d ? BUSY_D : BUSY_I;
          last_d_d      = pick_d;
          req_d         = req_sel;
          mem_request_d = 1'b1;
          if_gnt_d      = !pick_d;
          d_gnt_d       = pick_d;
          cnt_clr       = 1'b1;
        end
      end
      BUSY_I, BUSY_D: begin
        // A response arriving on the terminal cycle still counts as success.
        if (mem_valid || cnt_tc) begin
          state_d       = IDLE;
          mem_request_d = 1'b0;
          if (state_q == BUSY_D) begin
            d_valid_d = 1'b1;
            d_err_d   = !mem_valid;
            d_rdata_d = mem_valid ? mem_rdata : '0;
          end else begin
            if_valid_d = 1'b1;
            if_err_d   = !mem_valid;
            if_rdata_d = mem_valid ? mem_rdata : '0;
          end
        end else begin
          cnt_en = 1'b1;
        end
      end
      default: begin
        state_d       = IDLE;
        mem_request_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      last_d_q      <= 1'b1;
      req_q         <= '0;
      mem_request_q <= 1'b0;
      if_gnt_q      <= 1'b0;
      d_gnt_q       <= 1'b0;
      if_valid_q    <= 1'b0;
      d_valid_q     <= 1'b0;
      if_err_q      <= 1'b0;
      d_err_q       <= 1'b0;
      if_rdata_q    <= '0;
      d_rdata_q     <= '0;
    end else begin
      state_q       <= state_d;
      last_d_q      <= last_d_d;
      req_q         <= req_d;
      mem_request_q <= mem_request_d;
      if_gnt_q      <= if_gnt_d;
      d_gnt_q       <= d_gnt_d;
      if_valid_q    <= if_valid_d;
      d_valid_q     <= d_valid_d;
      if_err_q      <= if_err_d;
      d_err_q       <= d_err_d;
      if_rdata_q    <= if_rdata_d;
      d_rdata_q     <= d_rdata_d;
    end
  end

  arb_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk   (clk),
    .rst   (rst),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .tc_o  (cnt_tc)
  );

  assign if_gnt      = if_gnt_q;
  assign if_valid    = if_valid_q;
  assign if_err      = if_err_q;
  assign if_rdata    = if_rdata_q;
  assign d_gnt       = d_gnt_q;
  assign d_valid     = d_valid_q;
  assign d_err       = d_err_q;
  assign d_rdata     = d_rdata_q;
  assign mem_request = mem_request_q;
  assign mem_we_re   = req_q.we_re;
  assign mem_mask    = req_q.mask;
  assign mem_addr    = req_q.addr;
  assign mem_wdata   = req_q.wdata;

endmodule
